// File: rtl/adc_sample_fifo.sv
// Captures ADC samples on in_irq into a first-word-fall-through FIFO with valid/ready output.
// Define ADC_FIFO_AVG_EN to push one truncated average per 2^AVG_LOG2 captured samples.
module adc_sample_fifo #(
  parameter int unsigned DW         = 12,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned AVG_LOG2   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         in_data,
  input  logic                  in_irq,
  output logic [DW-1:0]         out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  clr_ovf
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic [DW-1:0] push_data;
  logic          empty;
  logic          full;
  logic          pop;
  logic          wr_en;

`ifdef ADC_FIFO_AVG_EN
  localparam int unsigned AW = DW + AVG_LOG2;

  logic [AW-1:0]       acc;
  logic [AW-1:0]       acc_sum;
  logic [AVG_LOG2-1:0] cnt;

  assign acc_sum   = acc + AW'(in_data);
  assign push      = in_irq && (cnt == '1);
  assign push_data = DW'(acc_sum >> AVG_LOG2);

  // Accumulator restarts after every completed group, whether or not the push was accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (in_irq) begin
      if (cnt == '1) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_sum;
        cnt <= cnt + 1'b1;
      end
    end
  end
`else
  assign push      = in_irq;
  assign push_data = in_data;

  // AVG_LOG2 only matters when averaging is built in
  if (AVG_LOG2 > 0) begin : g_avg_disabled
  end
`endif

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                     (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot a full FIFO would otherwise reject
  assign wr_en     = push && (!full || pop);
  assign level     = wr_ptr - rd_ptr;
  assign out_data  = out_valid ? mem[rd_ptr[PW-2:0]] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PW-2:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky drop flag; a new drop outranks a clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed self-checking bench for adc_sample_fifo; follows ADC_FIFO_AVG_EN if defined.
module tb_adc_sample_fifo;

`ifdef ADC_FIFO_AVG_EN
  localparam int unsigned AVG_N = 4;
`else
  localparam int unsigned AVG_N = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] in_data;
  logic        in_irq;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  level;
  logic        overflow;
  logic        clr_ovf;

  int checks = 0;
  int errors = 0;

  adc_sample_fifo #(.DW(12), .DEPTH_LOG2(4), .AVG_LOG2(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_irq    (in_irq),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        irq;
    logic [11:0] data;
    logic        rdy;
    logic        clr;
    logic        e_valid;
    logic [11:0] e_data;
    logic [4:0]  e_level;
    logic        e_ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic ev, input logic [11:0] ed,
                           input logic [4:0] el, input logic eo);
    chk({name, ".valid"}, int'(out_valid), int'(ev));
    if (ev) chk({name, ".data"}, int'(out_data), int'(ed));
    chk({name, ".level"}, int'(level), int'(el));
    chk({name, ".ovf"}, int'(overflow), int'(eo));
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge
  task automatic cyc(input logic irq, input logic [11:0] d, input logic rdy, input logic clr);
    in_irq = irq; in_data = d; out_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    #1;
    in_irq = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
  endtask

  // Enough strobes of value v to produce exactly one FIFO push (average of v is v)
  task automatic push_sample(input logic [11:0] v, input logic rdy, input logic clr);
    for (int i = 0; i < int'(AVG_N) - 1; i++) cyc(1'b1, v, 1'b0, 1'b0);
    cyc(1'b1, v, rdy, clr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_irq = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;

    //            irq  data     rdy  clr  valid e_data   lvl  ovf
    vecs[0] = '{1'b1, 12'hABC, 1'b0, 1'b0, 1'b1, 12'hABC, 5'd1, 1'b0};
    vecs[1] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000, 5'd0, 1'b0};
    vecs[2] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000, 5'd0, 1'b0};
    vecs[3] = '{1'b1, 12'h123, 1'b1, 1'b0, 1'b1, 12'h123, 5'd1, 1'b0};
    vecs[4] = '{1'b1, 12'h456, 1'b0, 1'b0, 1'b1, 12'h123, 5'd2, 1'b0};
    vecs[5] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 12'h456, 5'd1, 1'b0};
    vecs[6] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000, 5'd0, 1'b0};

    do_reset();
    chk_state("reset", 1'b0, 12'h000, 5'd0, 1'b0);
    chk("reset.out_data", int'(out_data), 0);

    foreach (vecs[i]) begin
      if (vecs[i].irq) push_sample(vecs[i].data, vecs[i].rdy, vecs[i].clr);
      else             cyc(1'b0, vecs[i].data, vecs[i].rdy, vecs[i].clr);
      chk_state($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                vecs[i].e_level, vecs[i].e_ovf);
    end

    // 20 pushes into a 16-deep FIFO: the 17th onward are dropped
    for (int i = 0; i < 20; i++) begin
      push_sample(12'(i), 1'b0, 1'b0);
      chk_state($sformatf("fill%0d", i), 1'b1, 12'h000,
                5'((i + 1 > 16) ? 16 : i + 1), (i >= 16));
    end
    for (int k = 0; k < 16; k++) begin
      chk_state($sformatf("drain%0d", k), 1'b1, 12'(k), 5'(16 - k), 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    chk_state("drained", 1'b0, 12'h000, 5'd0, 1'b1);

    // Full FIFO with simultaneous push and pop
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("clr_ovf", int'(overflow), 0);
    for (int i = 0; i < 16; i++) push_sample(12'h100 + 12'(i), 1'b0, 1'b0);
    chk_state("full", 1'b1, 12'h100, 5'd16, 1'b0);
    push_sample(12'h7EE, 1'b1, 1'b0);
    chk_state("full_push_pop", 1'b1, 12'h101, 5'd16, 1'b0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("pp_order%0d", k), int'(out_data), (k < 15) ? 12'h101 + k : 12'h7EE);
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    chk_state("pp_empty", 1'b0, 12'h000, 5'd0, 1'b0);

    // Drop and clear in the same cycle: set wins
    for (int i = 0; i < 16; i++) push_sample(12'h200 + 12'(i), 1'b0, 1'b0);
    push_sample(12'h3FF, 1'b0, 1'b0);
    chk_state("drop", 1'b1, 12'h200, 5'd16, 1'b1);
    push_sample(12'h3FE, 1'b0, 1'b1);
    chk_state("drop_and_clr", 1'b1, 12'h200, 5'd16, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk_state("clr_alone", 1'b1, 12'h200, 5'd16, 1'b0);

    // Reset mid-stream discards queued entries and any partial average
    do_reset();
    for (int i = 0; i < 5; i++) push_sample(12'h050 + 12'(i), 1'b0, 1'b0);
    cyc(1'b1, 12'd100, 1'b0, 1'b0);
    cyc(1'b1, 12'd100, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    chk_state("midrst", 1'b0, 12'h000, 5'd0, 1'b0);
    chk("midrst.out_data", int'(out_data), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_sample(12'd8, 1'b0, 1'b0);
    chk_state("after_rst", 1'b1, 12'd8, 5'd1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk_state("after_rst_pop", 1'b0, 12'h000, 5'd0, 1'b0);

`ifdef ADC_FIFO_AVG_EN
    // Averaging: truncation, full-scale headroom, incomplete groups
    cyc(1'b1, 12'd10, 1'b0, 1'b0);
    cyc(1'b1, 12'd11, 1'b0, 1'b0);
    cyc(1'b1, 12'd12, 1'b0, 1'b0);
    chk_state("avg_partial", 1'b0, 12'h000, 5'd0, 1'b0);
    cyc(1'b1, 12'd14, 1'b0, 1'b0);
    chk_state("avg_47", 1'b1, 12'd11, 5'd1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 12'hFFF, 1'b0, 1'b0);
    chk_state("avg_max_lvl", 1'b1, 12'd11, 5'd2, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk_state("avg_max", 1'b1, 12'hFFF, 5'd1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 12'd7, 1'b0, 1'b0);
    chk_state("avg_three", 1'b1, 12'hFFF, 5'd1, 1'b0);
    cyc(1'b1, 12'd11, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk_state("avg_fourth", 1'b1, 12'd8, 5'd1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
